usb_rx_response_ctrl: RTL and testbench
=======================================

// Module: usb_rx_response_ctrl
// PURPOSE
//  Schedules the USB receive decoder for the host-side protocol FSM.
//  - When the FSM expects a reply, the block arms the decoder and runs a turnaround timeout.
//  - It classifies the decoded packet by PID and CRC status, and holds one result until the FSM accepts it.
//  - Sits between the decoder (pkt, pktOutAvail, CRC check) and the protocol FSM.
// PARAMETERS
//  TIMEOUT_CYC  255  cycles in ARMED before a TIMEOUT result is reported (legal range 2..65535)
//  ERR_W        8    width of the saturating error and drop counters
// PORTS
//  clk             in   1      sole clock, rising edge
//  rst             in   1      asynchronous, active-high reset
//  expect_req      in   1      1-cycle pulse from FSM: a reply packet is expected
//  expect_data     in   1      sampled with expect_req; 1 = DATA0/DATA1 expected, 0 = handshake expected
//  dec_pkt_avail   in   1      decoder packet-complete strobe (1 cycle)
//  dec_pkt         in   99     decoder packet; [7:4] = PID, [3:0] = nPID, [71:8] = data payload
//  dec_crc_ok      in   1      decoder CRC residue match; valid with dec_pkt_avail
//  dec_en          out  1      enables the decoder bit input; 1 only in ARMED
//  res_valid       out  1      result held for the FSM
//  res_ready       in   1      FSM accepts the result
//  res_code        out  3      rx_result_e (see package)
//  res_payload     out  64     data payload; 0 unless res_code = RES_DATA
//  busy            out  1      1 when not IDLE
//  expect_err      out  1      1-cycle pulse: expect_req arrived while busy
//  err_cnt         out  ERR_W  saturating count of non-OK results
//  drop_cnt        out  ERR_W  saturating count of packets arriving while not ARMED
// BEHAVIOUR
//  Reset
//   - state = IDLE.
//   - dec_en, res_valid, busy and expect_err = 0.
//   - res_code = RES_NONE, res_payload = 0, counters = 0, timer = 0.
//   - Reset asserted mid-operation aborts everything; a held result is lost.
//  States
//   - IDLE: expect_req -> ARMED next cycle. On that edge latch expect_data and clear the timer.
//   - ARMED: dec_en = 1; timer increments each cycle.
//     - dec_pkt_avail -> HOLD, with the result registered on the same edge.
//     - Otherwise, timer == TIMEOUT_CYC-1 -> HOLD with res_code = RES_TIMEOUT.
//     - If both occur in the same cycle, the packet wins.
//   - HOLD: res_valid = 1; outputs stable until res_valid & res_ready. On that edge -> IDLE.
//  Latency
//   - res_valid rises on the cycle after dec_pkt_avail, or on the cycle after timeout expiry.
//   - dec_en falls on that same edge.
//  Classification (evaluated in ARMED on dec_pkt_avail)
//   - pid_ok = (dec_pkt[7:4] == ~dec_pkt[3:0]). If !pid_ok -> RES_PID_ERR.
//   - expect_data = 1:
//     - PID DATA0/DATA1 with dec_crc_ok -> RES_DATA, res_payload = dec_pkt[71:8].
//     - PID DATA0/DATA1 without dec_crc_ok -> RES_CRC_ERR.
//     - Any other valid PID -> RES_UNEXP.
//   - expect_data = 0 (handshake packets carry no CRC; dec_crc_ok is ignored):
//     - ACK -> RES_ACK; NAK -> RES_NAK; STALL -> RES_STALL.
//     - Any other valid PID -> RES_UNEXP.
//  Counters
//   - err_cnt += 1 on entering HOLD with res_code in {PID_ERR, CRC_ERR, UNEXP, TIMEOUT}.
//   - drop_cnt += 1 on dec_pkt_avail in IDLE or HOLD; the dropped packet is otherwise ignored.
//   - Both counters saturate at 2^ERR_W-1 and never wrap.
//  Other boundary rules
//   - expect_req in ARMED or HOLD: ignored, expect_err pulses next cycle, state unchanged.
//   - expect_req in the same cycle as the HOLD handshake: ignored, and expect_err pulses
//     (the block is still busy that cycle).
//   - res_ready while !res_valid: no effect.
// STRUCTURE
//  Shared package usb_pkg:
//   - typedef enum logic [2:0] rx_result_e
//     {RES_NONE, RES_DATA, RES_ACK, RES_NAK, RES_STALL, RES_CRC_ERR, RES_PID_ERR, RES_TIMEOUT};
//     RES_UNEXP shares encoding 3'b000 with RES_NONE and is distinguished by res_valid.
//   - PID constants: DATA0 4'b0011, DATA1 4'b1011, ACK 4'b0010, NAK 4'b1010, STALL 4'b1110.
//  Local state enum {IDLE, ARMED, HOLD}.
//  One sub-module: sat_counter (ERR_W-bit saturating incrementer), instantiated twice.
//   The timeout timer stays inline.
// TESTING
//  1. expect_req with expect_data = 1; 20 cycles later dec_pkt_avail with PID 4'b0011/nPID 4'b1100,
//     payload 64'hDEADBEEF_01234567, crc_ok = 1
//     -> next cycle res_valid = 1, res_code = RES_DATA, payload matches, dec_en = 0, err_cnt = 0.
//  2. Same as 1 but dec_crc_ok = 0 -> RES_CRC_ERR, payload = 0, err_cnt = 1.
//  3. expect_data = 0, packet with nPID 4'b0010 and PID 4'b0010 (bad complement) -> RES_PID_ERR.
//     Then an ACK packet -> RES_ACK, err_cnt = 1.
//  4. TIMEOUT_CYC = 16, no packet -> res_valid rises exactly 17 cycles after expect_req.
//     Repeat with dec_pkt_avail on the expiry cycle -> packet result, not RES_TIMEOUT.
//  5. Hold res_ready = 0 for 10 cycles; issue expect_req and dec_pkt_avail during HOLD
//     -> outputs unchanged, expect_err pulses once, drop_cnt = 1.
//  6. Assert rst during ARMED -> all outputs return to reset values immediately.
//     Force 300 errors with ERR_W = 8 -> err_cnt saturates at 255.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared USB receive definitions: result codes, PID constants and the
// packet classification rule used by the response controller.
package usb_pkg;

   typedef enum logic [2:0] {
      RES_NONE, RES_DATA, RES_ACK, RES_NAK, RES_STALL, RES_CRC_ERR, RES_PID_ERR, RES_TIMEOUT
   } rx_result_e;

   // An unexpected PID reuses the NONE encoding; res_valid tells them apart.
   localparam rx_result_e RES_UNEXP = RES_NONE;

   localparam logic [3:0] PID_DATA0 = 4'b0011;
   localparam logic [3:0] PID_DATA1 = 4'b1011;
   localparam logic [3:0] PID_ACK   = 4'b0010;
   localparam logic [3:0] PID_NAK   = 4'b1010;
   localparam logic [3:0] PID_STALL = 4'b1110;

   function automatic rx_result_e classify_pkt(input logic [3:0] pid, input logic [3:0] npid,
                                               input logic exp_data, input logic crc_ok);
      rx_result_e code;
      code = RES_UNEXP;
      if (pid != ~npid) begin
         code = RES_PID_ERR;
      end else if (exp_data) begin
         if (pid == PID_DATA0 || pid == PID_DATA1)
            code = crc_ok ? RES_DATA : RES_CRC_ERR;
      end else begin
         case (pid)
            PID_ACK:   code = RES_ACK;
            PID_NAK:   code = RES_NAK;
            PID_STALL: code = RES_STALL;
            default:   code = RES_UNEXP;
         endcase
      end
      return code;
   endfunction

   function automatic logic is_err_code(input rx_result_e code);
      return (code == RES_UNEXP) || (code == RES_CRC_ERR) ||
             (code == RES_PID_ERR) || (code == RES_TIMEOUT);
   endfunction

endpackage

// File: rtl/usb_rx_response_ctrl_sat_counter.sv
// Saturating up-counter: increments on inc and sticks at all-ones.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (inc && (cnt != '1))
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/usb_rx_response_ctrl.sv
// Arms the USB receive decoder when a reply is expected, times out the
// turnaround, classifies the decoded packet and holds the result for the FSM.
module usb_rx_response_ctrl
   import usb_pkg::*;
#(
   parameter int TIMEOUT_CYC = 255,
   parameter int ERR_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             expect_req,
   input  logic             expect_data,
   input  logic             dec_pkt_avail,
   input  logic [98:0]      dec_pkt,
   input  logic             dec_crc_ok,
   output logic             dec_en,
   output logic             res_valid,
   input  logic             res_ready,
   output rx_result_e       res_code,
   output logic [63:0]      res_payload,
   output logic             busy,
   output logic             expect_err,
   output logic [ERR_W-1:0] err_cnt,
   output logic [ERR_W-1:0] drop_cnt
);

   typedef enum logic [1:0] {IDLE, ARMED, HOLD} state_e;

   state_e      state_q, state_d;
   logic [15:0] timer_q;
   logic        exp_data_q;
   logic        expect_err_q;
   rx_result_e  res_code_q;
   logic [63:0] res_payload_q;
   rx_result_e  pkt_code;
   logic        timeout, handshake, err_inc, drop_inc;
   logic        unused_pkt_bits;

   assign unused_pkt_bits = ^dec_pkt[98:72];
   assign pkt_code  = classify_pkt(dec_pkt[7:4], dec_pkt[3:0], exp_data_q, dec_crc_ok);
   assign timeout   = (timer_q == 16'(TIMEOUT_CYC - 1));
   assign handshake = (state_q == HOLD) && res_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (expect_req) state_d = ARMED;
         ARMED:   if (dec_pkt_avail || timeout) state_d = HOLD;
         HOLD:    if (res_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Result is captured on the edge that leaves ARMED; the packet beats the timeout.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timer_q       <= '0;
         exp_data_q    <= 1'b0;
         expect_err_q  <= 1'b0;
         res_code_q    <= RES_NONE;
         res_payload_q <= '0;
      end else begin
         expect_err_q <= expect_req && (state_q != IDLE);
         case (state_q)
            IDLE: begin
               if (expect_req) begin
                  exp_data_q <= expect_data;
                  timer_q    <= '0;
               end
            end
            ARMED: begin
               timer_q <= timer_q + 16'd1;
               if (dec_pkt_avail) begin
                  res_code_q    <= pkt_code;
                  res_payload_q <= (pkt_code == RES_DATA) ? dec_pkt[71:8] : 64'd0;
               end else if (timeout) begin
                  res_code_q    <= RES_TIMEOUT;
                  res_payload_q <= '0;
               end
            end
            HOLD: begin
               if (handshake) begin
                  res_code_q    <= RES_NONE;
                  res_payload_q <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign err_inc  = (state_q == ARMED) &&
                     ((dec_pkt_avail && is_err_code(pkt_code)) || (!dec_pkt_avail && timeout));
   assign drop_inc = dec_pkt_avail && (state_q != ARMED);

   sat_counter #(.W(ERR_W)) u_err_cnt (
      .clk (clk),
      .rst (rst),
      .inc (err_inc),
      .cnt (err_cnt)
   );

   sat_counter #(.W(ERR_W)) u_drop_cnt (
      .clk (clk),
      .rst (rst),
      .inc (drop_inc),
      .cnt (drop_cnt)
   );

   assign dec_en      = (state_q == ARMED);
   assign res_valid   = (state_q == HOLD);
   assign busy        = (state_q != IDLE);
   assign expect_err  = expect_err_q;
   assign res_code    = res_code_q;
   assign res_payload = res_payload_q;

endmodule

// File: tb/tb_usb_rx_response_ctrl.sv
// Scoreboard bench for usb_rx_response_ctrl: a driver pushes expected results
// from a rule-level reference model, a negedge monitor pops and compares.
module tb_usb_rx_response_ctrl;

   localparam int TO    = 16;
   localparam int ERR_W = 8;
   localparam int CMAX  = (1 << ERR_W) - 1;

   localparam logic [2:0] C_DATA = 3'd1, C_ACK = 3'd2, C_NAK = 3'd3, C_STALL = 3'd4,
                          C_CRC = 3'd5, C_PID = 3'd6, C_TMO = 3'd7, C_UNEXP = 3'd0;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             expect_req = 1'b0, expect_data = 1'b0;
   logic             dec_pkt_avail = 1'b0, dec_crc_ok = 1'b0;
   logic [98:0]      dec_pkt = '0;
   logic             res_ready = 1'b0;
   logic             dec_en, res_valid, busy, expect_err;
   logic [2:0]       res_code;
   logic [63:0]      res_payload;
   logic [ERR_W-1:0] err_cnt, drop_cnt;

   usb_rx_response_ctrl #(.TIMEOUT_CYC(TO), .ERR_W(ERR_W)) dut (
      .clk (clk), .rst (rst), .expect_req (expect_req), .expect_data (expect_data),
      .dec_pkt_avail (dec_pkt_avail), .dec_pkt (dec_pkt), .dec_crc_ok (dec_crc_ok),
      .dec_en (dec_en), .res_valid (res_valid), .res_ready (res_ready),
      .res_code (res_code), .res_payload (res_payload), .busy (busy),
      .expect_err (expect_err), .err_cnt (err_cnt), .drop_cnt (drop_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  code;
      logic [63:0] pl;
      int          armed;
      int          err;
      int          drop;
   } exp_t;

   exp_t sbq[$];
   int   tests = 0, fails = 0;
   int   m_err = 0, m_drop = 0, m_experr = 0;
   int   seen_experr = 0, armed_cnt = 0;
   bit   prev_valid = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int sat(input int v);
      return (v < CMAX) ? v + 1 : v;
   endfunction

   // Reference rule: complement check first, then what the FSM was waiting for.
   function automatic logic [2:0] ref_class(input bit e, input logic [3:0] pid,
                                            input logic [3:0] npid, input bit crc);
      if ((pid ^ npid) != 4'hF) return C_PID;
      if (e) return (pid[2:0] == 3'b011) ? (crc ? C_DATA : C_CRC) : C_UNEXP;
      case (pid)
         4'd2:    return C_ACK;
         4'd10:   return C_NAK;
         4'd14:   return C_STALL;
         default: return C_UNEXP;
      endcase
   endfunction

   task automatic txn(input bit e, input int k, input logic [3:0] pid, input logic [3:0] npid,
                      input logic [63:0] pl, input bit crc, input int hold,
                      input bit req_hold, input bit drop_hold, input bit req_hs);
      exp_t it;
      int   n;
      expect_data = e;
      expect_req  = 1'b1;
      step();
      expect_req  = 1'b0;
      expect_data = 1'b0;
      if (k < TO) begin
         repeat (k) step();
         it.code = ref_class(e, pid, npid, crc);
         it.armed = k + 1;
         dec_pkt = {27'($urandom), pl, pid, npid};
         dec_crc_ok = crc;
         dec_pkt_avail = 1'b1;
      end else begin
         it.code = C_TMO;
         it.armed = TO;
      end
      it.pl = (it.code == C_DATA) ? pl : 64'd0;
      if (it.code inside {C_UNEXP, C_CRC, C_PID, C_TMO}) m_err = sat(m_err);
      it.err = m_err;
      it.drop = m_drop;
      sbq.push_back(it);
      if (k < TO) begin
         step();
         dec_pkt_avail = 1'b0;
         dec_crc_ok = 1'b0;
      end
      n = 0;
      while (!res_valid && n < TO + 8) begin
         step();
         n++;
      end
      if (!res_valid) begin
         tests++;
         fails++;
         $display("FAIL result_wait: res_valid never rose within %0d cycles", TO + 8);
         return;
      end
      for (int i = 0; i < hold; i++) begin
         if (i == 0 && req_hold) begin
            expect_req = 1'b1;
            m_experr++;
         end
         if (i == 0 && drop_hold) begin
            dec_pkt = {27'($urandom), $urandom, $urandom, 8'($urandom)};
            dec_pkt_avail = 1'b1;
            m_drop = sat(m_drop);
         end
         step();
         expect_req = 1'b0;
         dec_pkt_avail = 1'b0;
      end
      res_ready = 1'b1;
      if (req_hs) begin
         expect_req = 1'b1;
         m_experr++;
      end
      step();
      res_ready = 1'b0;
      expect_req = 1'b0;
   endtask

   task automatic rand_txn();
      logic [3:0] pid, npid;
      int sel;
      if ($urandom_range(0, 4) == 0) begin
         dec_pkt = {27'($urandom), $urandom, $urandom, 8'($urandom)};
         dec_pkt_avail = 1'b1;
         res_ready = 1'b1;
         m_drop = sat(m_drop);
         step();
         dec_pkt_avail = 1'b0;
         res_ready = 1'b0;
      end
      sel = $urandom_range(0, 6);
      case (sel)
         0: pid = 4'b0011;
         1: pid = 4'b1011;
         2: pid = 4'b0010;
         3: pid = 4'b1010;
         4: pid = 4'b1110;
         default: pid = 4'($urandom);
      endcase
      npid = ($urandom_range(0, 9) == 0) ? 4'($urandom) : ~pid;
      txn(1'($urandom_range(0, 1)), $urandom_range(0, TO + 3), pid, npid, {$urandom, $urandom},
          1'($urandom_range(0, 1)), $urandom_range(0, 4), $urandom_range(0, 3) == 0,
          $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
   endtask

   always @(negedge clk) begin
      if (rst) begin
         armed_cnt  = 0;
         prev_valid = 1'b0;
      end else begin
         if (expect_err) seen_experr++;
         if (dec_en) begin
            armed_cnt++;
            chk("busy_armed", busy, 1'b1);
         end
         if (res_valid) begin
            if (sbq.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_result: res_valid with empty scoreboard, code %0d", res_code);
            end else begin
               chk("res_code", res_code, sbq[0].code);
               chk("res_payload", res_payload, sbq[0].pl);
               chk("dec_en_hold", dec_en, 1'b0);
               if (!prev_valid) begin
                  chk("armed_cycles", armed_cnt, sbq[0].armed);
                  chk("err_cnt", err_cnt, sbq[0].err);
                  chk("drop_cnt", drop_cnt, sbq[0].drop);
                  armed_cnt = 0;
               end
               if (res_ready) void'(sbq.pop_front());
            end
         end
         prev_valid = res_valid;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) step();
      chk("rst_dec_en", dec_en, 1'b0);
      chk("rst_res_valid", res_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_res_code", res_code, 3'd0);
      rst = 1'b0;
      step();
      chk("idle_expect_err", expect_err, 1'b0);
      chk("idle_payload", res_payload, 64'd0);
      chk("idle_err_cnt", err_cnt, 0);
      chk("idle_drop_cnt", drop_cnt, 0);

      // Directed cases: data ok, CRC error, PID error, ACK, timeout, late packet, long hold.
      txn(1, 20 % TO, 4'b0011, 4'b1100, 64'hDEADBEEF_01234567, 1, 0, 0, 0, 0);
      txn(1, 5, 4'b0011, 4'b1100, 64'hDEADBEEF_01234567, 0, 0, 0, 0, 0);
      txn(0, 2, 4'b0010, 4'b0010, 64'h1111, 1, 0, 0, 0, 0);
      txn(0, 2, 4'b0010, 4'b1101, 64'h2222, 0, 1, 0, 0, 0);
      txn(0, TO + 2, 4'b0000, 4'b0000, 64'd0, 0, 0, 0, 0, 0);
      txn(1, TO - 1, 4'b1011, 4'b0100, 64'hCAFEF00D_55AA55AA, 1, 0, 0, 0, 0);
      txn(0, 3, 4'b1010, 4'b0101, 64'd0, 0, 10, 1, 1, 0);
      txn(0, 0, 4'b1110, 4'b0001, 64'd0, 0, 2, 0, 0, 1);

      repeat (150) rand_txn();

      // Abort from ARMED with an asynchronous reset.
      expect_data = 1'b1;
      expect_req  = 1'b1;
      step();
      expect_req  = 1'b0;
      repeat (3) step();
      chk("armed_dec_en", dec_en, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("abort_dec_en", dec_en, 1'b0);
      chk("abort_busy", busy, 1'b0);
      chk("abort_res_valid", res_valid, 1'b0);
      chk("abort_err_cnt", err_cnt, 0);
      chk("abort_drop_cnt", drop_cnt, 0);
      chk("abort_code", res_code, 3'd0);
      m_err  = 0;
      m_drop = 0;
      step();
      rst = 1'b0;
      step();

      // Saturation of the error counter.
      for (int i = 0; i < 300; i++)
         txn(0, 0, 4'($urandom), 4'b0000 ^ 4'($urandom_range(0, 14)) ^ 4'h0, 64'd0, 0, 0, 0, 0, 0);
      repeat (3) step();
      chk("err_cnt_sat", err_cnt, m_err);
      chk("err_cnt_255", err_cnt, CMAX);
      chk("drop_cnt_final", drop_cnt, m_drop);
      chk("expect_err_pulses", seen_experr, m_experr);
      chk("scoreboard_empty", sbq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
